serdes_tx_framer: RTL and testbench

SERDES_TX_FRAMER -- requirements
Module: serdes_tx_framer

---
 rtl/serdes_tx_pkg.sv | 18 +
 rtl/serdes_tx_framer_if.sv | 22 ++
 rtl/tx_sat_counter.sv | 29 ++
 rtl/serdes_tx_framer.sv | 135 +++++++++++++
 tb/tb_serdes_tx_framer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/serdes_tx_pkg.sv
// Shared types and defaults for the serializer transmit framer.
package serdes_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_PLL,
    ST_TRAIN,
    ST_DATA
  } state_t;

  localparam logic [9:0] DEF_TRAIN_PATTERN = 10'b1111100000;
  localparam logic [9:0] DEF_IDLE_PATTERN  = 10'b1010101010;

  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/serdes_tx_framer_if.sv
// Payload valid/ready handshake into the transmit framer.
interface serdes_tx_framer_if #(
  parameter int WIDTH = 10
);

  logic [WIDTH-1:0] TX_DATA;
  logic             TX_VALID;
  logic             TX_READY;

  modport master (
    output TX_DATA,
    output TX_VALID,
    input  TX_READY
  );

  modport slave (
    input  TX_DATA,
    input  TX_VALID,
    output TX_READY
  );

endinterface

// File: rtl/tx_sat_counter.sv
// Up-counter that holds at LIMIT; clear wins over enable.
module tx_sat_counter #(
  parameter int W     = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic at_limit
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] count;

  assign at_limit = (count == LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !at_limit) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/serdes_tx_framer.sv
// Serializer word framer: PLL wait, link training, then payload
// with a periodic alignment word.
module serdes_tx_framer
  import serdes_tx_pkg::*;
#(
  parameter int         WIDTH          = 10,
  parameter int         PLL_WAIT       = 255,
  parameter int         TRAIN_WORDS    = 64,
  parameter int         ALIGN_INTERVAL = 1024,
  parameter logic [9:0] TRAIN_PATTERN  = DEF_TRAIN_PATTERN,
  parameter logic [9:0] IDLE_PATTERN   = DEF_IDLE_PATTERN
) (
  input  logic              CLK_IN,
  input  logic              RST,
  input  logic              EN,
  input  logic              PLL_LOCK,
  input  logic              LINK_READY,
  input  logic              RETRAIN,
  serdes_tx_framer_if.slave tx,
  output logic [WIDTH-1:0]  Q,
  output logic              LOAD_WORD,
  output logic              OE,
  output logic              TRAINING,
  output logic              LINK_UP
);

  localparam logic [WIDTH-1:0] TRAIN_W = TRAIN_PATTERN[WIDTH-1:0];
  localparam logic [WIDTH-1:0] IDLE_W  = IDLE_PATTERN[WIDTH-1:0];

  state_t state;
  state_t nxt;

  logic in_wait;
  logic in_train;
  logic in_data;
  logic lock_done;
  logic train_done;
  logic word_wrap;
  logic align;
  logic take;

  assign in_wait  = (state == ST_WAIT_PLL);
  assign in_train = (state == ST_TRAIN);
  assign in_data  = (state == ST_DATA);

  // The last word slot of each interval carries the alignment word
  assign align       = in_data & word_wrap;
  assign tx.TX_READY = in_data & ~word_wrap;
  assign take        = tx.TX_VALID & tx.TX_READY;

  tx_sat_counter #(
    .W     (cnt_width(PLL_WAIT)),
    .LIMIT (PLL_WAIT)
  ) u_lock (
    .clk      (CLK_IN),
    .rst_n    (RST),
    .clr      (~in_wait | ~PLL_LOCK),
    .en       (PLL_LOCK),
    .at_limit (lock_done)
  );

  tx_sat_counter #(
    .W     (cnt_width(TRAIN_WORDS)),
    .LIMIT (TRAIN_WORDS)
  ) u_train (
    .clk      (CLK_IN),
    .rst_n    (RST),
    .clr      (~in_train),
    .en       (in_train),
    .at_limit (train_done)
  );

  tx_sat_counter #(
    .W     (cnt_width(ALIGN_INTERVAL - 1)),
    .LIMIT (ALIGN_INTERVAL - 1)
  ) u_word (
    .clk      (CLK_IN),
    .rst_n    (RST),
    .clr      (~in_data | word_wrap),
    .en       (in_data),
    .at_limit (word_wrap)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:     nxt = ST_WAIT_PLL;
      ST_WAIT_PLL: if (lock_done) nxt = ST_TRAIN;
      ST_TRAIN:    if (train_done && LINK_READY) nxt = ST_DATA;
      ST_DATA:     if (RETRAIN) nxt = ST_TRAIN;
      default:     nxt = ST_IDLE;
    endcase
    if ((in_train || in_data) && !PLL_LOCK) nxt = ST_WAIT_PLL;
    if (!EN) nxt = ST_IDLE;
  end

  // Outputs are decoded from the next state so they line up with it
  always_ff @(posedge CLK_IN or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      Q         <= '0;
      LOAD_WORD <= 1'b0;
      OE        <= 1'b0;
      TRAINING  <= 1'b0;
      LINK_UP   <= 1'b0;
    end else begin
      state     <= nxt;
      Q         <= '0;
      LOAD_WORD <= 1'b0;
      OE        <= 1'b0;
      TRAINING  <= 1'b0;
      LINK_UP   <= 1'b0;
      unique case (nxt)
        ST_TRAIN: begin
          Q         <= TRAIN_W;
          LOAD_WORD <= 1'b1;
          OE        <= 1'b1;
          TRAINING  <= 1'b1;
        end
        ST_DATA: begin
          LOAD_WORD <= 1'b1;
          OE        <= 1'b1;
          LINK_UP   <= 1'b1;
          unique case (1'b1)
            align:   Q <= TRAIN_W;
            take:    Q <= tx.TX_DATA;
            default: Q <= IDLE_W;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serdes_tx_framer.sv
// Directed bench for serdes_tx_framer: bring-up table plus
// hand sequences for alignment, PLL loss, retrain and reset.
module tb_serdes_tx_framer;

  localparam int W = 10;
  localparam logic [9:0] TP = 10'h3E0;
  localparam logic [9:0] IP = 10'h2AA;

  typedef struct {
    logic       en;
    logic       lock;
    logic       lr;
    logic       valid;
    logic [9:0] data;
    logic       tr;
    logic       lu;
    logic       oe;
    logic       ld;
    logic [9:0] q;
    logic       rdy;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         pll_lock;
  logic         link_ready;
  logic         retrain;
  logic [W-1:0] q;
  logic         load_word;
  logic         oe;
  logic         training;
  logic         link_up;

  int tests = 0;
  int fails = 0;
  int dcnt;
  int ptr;
  int cyc;
  logic exp_rdy;
  vec_t vecs[$];

  always #5 clk = ~clk;

  serdes_tx_framer_if #(.WIDTH(W)) tx_if ();

  serdes_tx_framer #(
    .WIDTH          (W),
    .PLL_WAIT       (4),
    .TRAIN_WORDS    (8),
    .ALIGN_INTERVAL (16)
  ) dut (
    .CLK_IN     (clk),
    .RST        (rst),
    .EN         (en),
    .PLL_LOCK   (pll_lock),
    .LINK_READY (link_ready),
    .RETRAIN    (retrain),
    .tx         (tx_if),
    .Q          (q),
    .LOAD_WORD  (load_word),
    .OE         (oe),
    .TRAINING   (training),
    .LINK_UP    (link_up)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic chk_all(input string n, input logic tr, input logic lu,
                         input logic o, input logic ld,
                         input logic [9:0] eq, input logic rdy);
    chk({n, ".training"}, training, tr);
    chk({n, ".link_up"}, link_up, lu);
    chk({n, ".oe"}, oe, o);
    chk({n, ".load"}, load_word, ld);
    chk({n, ".q"}, q, eq);
    chk({n, ".ready"}, tx_if.TX_READY, rdy);
  endtask

  task automatic add(input logic e, input logic l, input logic r,
                     input logic v, input logic [9:0] d,
                     input logic tr, input logic lu, input logic o,
                     input logic ld, input logic [9:0] eq,
                     input logic rdy);
    vec_t t;
    t.en = e; t.lock = l; t.lr = r; t.valid = v; t.data = d;
    t.tr = tr; t.lu = lu; t.oe = o; t.ld = ld; t.q = eq; t.rdy = rdy;
    vecs.push_back(t);
  endtask

  // Nine TRAIN words with LINK_READY high, then LINK_UP
  task automatic train_to_data(input string n);
    for (int k = 1; k <= 9; k++) begin
      step();
      chk({n, ".lu"}, link_up, (k == 9));
      chk({n, ".tr"}, training, (k != 9));
    end
    chk({n, ".first_q"}, q, IP);
  endtask

  initial begin
    rst = 1'b0;
    en = 1'b0;
    pll_lock = 1'b0;
    link_ready = 1'b0;
    retrain = 1'b0;
    tx_if.TX_VALID = 1'b0;
    tx_if.TX_DATA = '0;

    // Bring-up: EN low, 5 WAIT_PLL words, 11 TRAIN, then DATA
    add(0, 1, 0, 0, 10'h000, 0, 0, 0, 0, 10'h000, 0);
    for (int i = 0; i < 5; i++)
      add(1, 1, 0, 0, 10'h000, 0, 0, 0, 0, 10'h000, 0);
    for (int i = 0; i < 11; i++)
      add(1, 1, 0, 0, 10'h000, 1, 0, 1, 1, TP, 0);
    add(1, 1, 1, 1, 10'h3FF, 0, 1, 1, 1, IP, 1);

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 10'h000, 0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en;
      pll_lock = vecs[i].lock;
      link_ready = vecs[i].lr;
      tx_if.TX_VALID = vecs[i].valid;
      tx_if.TX_DATA = vecs[i].data;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].tr, vecs[i].lu,
              vecs[i].oe, vecs[i].ld, vecs[i].q, vecs[i].rdy);
    end

    // Back-to-back payload with alignment insertion every 16th slot
    dcnt = 0;
    ptr = 1;
    cyc = 0;
    while (ptr <= 32 && cyc < 40) begin
      exp_rdy = (dcnt != 15);
      chk($sformatf("data_rdy%0d", cyc), tx_if.TX_READY, exp_rdy);
      tx_if.TX_VALID = 1'b1;
      tx_if.TX_DATA = 10'(ptr);
      step();
      if (exp_rdy) begin
        chk($sformatf("data_q%0d", ptr), q, ptr);
        ptr++;
      end else begin
        chk($sformatf("align_q%0d", cyc), q, TP);
      end
      dcnt = (dcnt == 15) ? 0 : dcnt + 1;
      cyc++;
    end
    chk("data_all_sent", ptr, 33);
    chk("data_cycles", cyc, 34);

    for (int k = 0; k < 3; k++) begin
      tx_if.TX_VALID = 1'b0;
      chk("idle_rdy", tx_if.TX_READY, 1'b1);
      step();
      chk($sformatf("idle_q%0d", k), q, IP);
      chk("idle_lu", link_up, 1'b1);
    end

    // PLL drop, re-lock (RETRAIN in WAIT_PLL is ignored), re-train
    pll_lock = 1'b0;
    tx_if.TX_VALID = 1'b1;
    tx_if.TX_DATA = 10'h155;
    step();
    chk_all("pll_drop", 0, 0, 0, 0, 10'h000, 0);
    pll_lock = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      retrain = (k == 1);
      step();
      chk($sformatf("relock%0d.tr", k), training, (k == 5));
    end
    retrain = 1'b0;
    chk("relock.q", q, TP);
    chk("relock.oe", oe, 1'b1);
    train_to_data("retrain_pll");

    // RETRAIN pulse in DATA
    tx_if.TX_DATA = 10'h123;
    chk("pre_retrain_rdy", tx_if.TX_READY, 1'b1);
    step();
    chk("pre_retrain_q", q, 10'h123);
    retrain = 1'b1;
    tx_if.TX_DATA = 10'h0AB;
    step();
    retrain = 1'b0;
    chk_all("retrain", 1, 0, 1, 1, TP, 0);
    train_to_data("retrain_req");

    // Asynchronous reset in the middle of a DATA cycle
    tx_if.TX_DATA = 10'h2F0;
    step();
    chk("pre_rst_q", q, 10'h2F0);
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 10'h000, 0);
    @(posedge clk);
    #1;
    chk_all("held_rst", 0, 0, 0, 0, 10'h000, 0);
    rst = 1'b1;
    tx_if.TX_VALID = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("rebring%0d.tr", k), training, (k == 6));
    end

    // EN low during TRAIN
    en = 1'b0;
    step();
    chk_all("en_low", 0, 0, 0, 0, 10'h000, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
